// File: rtl/raster_mem_arbiter.sv
// N-channel Avalon-MM round-robin arbiter with an in-order tag FIFO that routes read data back to the issuing channel.
// Optional per-channel grant and stall counters are built when RASTER_ARB_PERF_EN is defined.
module raster_mem_arbiter #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned ADDR_W      = 26,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_PENDING = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
   input  logic [NUM_CH-1:0]            ch_read,
   input  logic [NUM_CH-1:0]            ch_write,
   input  logic [NUM_CH*(DATA_W/8)-1:0] ch_byteenable,
   input  logic [NUM_CH*DATA_W-1:0]     ch_writedata,
   output logic [NUM_CH-1:0]            ch_waitrequest,
   output logic [DATA_W-1:0]            ch_readdata,
   output logic [NUM_CH-1:0]            ch_readdatavalid,
   output logic [ADDR_W-1:0]            m_address,
   output logic                         m_read,
   output logic                         m_write,
   output logic [DATA_W/8-1:0]          m_byteenable,
   output logic [DATA_W-1:0]            m_writedata,
   input  logic                         m_waitrequest,
   input  logic [DATA_W-1:0]            m_readdata,
   input  logic                         m_readdatavalid,
   output logic                         err_orphan
`ifdef RASTER_ARB_PERF_EN
   ,
   output logic [NUM_CH*32-1:0]         perf_grants,
   output logic [31:0]                  perf_stall
`endif
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CH_W  = $clog2(NUM_CH);
   localparam int unsigned PTR_W = $clog2(MAX_PENDING);

   logic [CH_W-1:0]   r_rr_ptr;
   logic              r_lock;
   logic [CH_W-1:0]   r_lock_ch;
   logic [CH_W-1:0]   r_tag_mem [MAX_PENDING];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_err;

   logic              w_full;
   logic [NUM_CH-1:0] w_elig;
   logic [CH_W-1:0]   w_gnt;
   logic              w_gnt_vld;
   logic              w_req_rd;
   logic              w_req_wr;
   logic              w_present;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic [CH_W-1:0]   w_head;

   assign w_full = (r_count == (PTR_W+1)'(MAX_PENDING));
   assign w_elig = ch_write | (ch_read & {NUM_CH{~w_full}});

   // Round-robin search from r_rr_ptr; a stalled grant stays locked until accepted.
   always_comb begin : grant_sel
      int v_idx;
      w_gnt     = r_rr_ptr;
      w_gnt_vld = 1'b0;
      v_idx     = 0;
      if (r_lock) begin
         w_gnt     = r_lock_ch;
         w_gnt_vld = 1'b1;
      end else begin
         for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= int'(NUM_CH)) v_idx = v_idx - int'(NUM_CH);
            if (w_elig[CH_W'(v_idx)]) begin
               w_gnt     = CH_W'(v_idx);
               w_gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin : down_mux
      m_address    = '0;
      m_byteenable = '0;
      m_writedata  = '0;
      w_req_rd     = 1'b0;
      w_req_wr     = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (w_gnt == CH_W'(i)) begin
            m_address    = ch_address[i*ADDR_W +: ADDR_W];
            m_byteenable = ch_byteenable[i*BE_W +: BE_W];
            m_writedata  = ch_writedata[i*DATA_W +: DATA_W];
            w_req_rd     = ch_read[i];
            w_req_wr     = ch_write[i];
         end
      end
   end

   // Reset gates the combinational request path so outputs idle immediately.
   assign w_present = ~reset & w_gnt_vld & (w_req_rd | w_req_wr);
   assign m_write   = w_present & w_req_wr;
   assign m_read    = w_present & w_req_rd & ~w_req_wr;
   assign w_accept  = w_present & ~m_waitrequest;
   assign w_push    = w_accept & m_read;
   assign w_pop     = ~reset & m_readdatavalid & (r_count != '0);
   assign w_head    = r_tag_mem[r_rd_ptr];

   always_comb begin : up_strobes
      for (int i = 0; i < int'(NUM_CH); i++) begin
         ch_waitrequest[i]   = ~(w_accept & (w_gnt == CH_W'(i)));
         ch_readdatavalid[i] = w_pop & (w_head == CH_W'(i));
      end
   end

   assign ch_readdata = m_readdata;
   assign err_orphan  = r_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rr_ptr  <= '0;
         r_lock    <= 1'b0;
         r_lock_ch <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + CH_W'(1);
         end else if (w_present) begin
            r_lock    <= 1'b1;
            r_lock_ch <= w_gnt;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
         if (m_readdatavalid && (r_count == '0)) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_tag_mem[r_wr_ptr] <= w_gnt;
   end

`ifdef RASTER_ARB_PERF_EN
   logic [31:0] r_perf_grants [NUM_CH];
   logic [31:0] r_perf_stall;

   // Saturating accept and stall counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_CH); i++) r_perf_grants[i] <= '0;
         r_perf_stall <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (w_accept && (w_gnt == CH_W'(i)) && (r_perf_grants[i] != '1))
               r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
         end
         if (w_present && m_waitrequest && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   always_comb begin : perf_pack
      for (int i = 0; i < int'(NUM_CH); i++) perf_grants[i*32 +: 32] = r_perf_grants[i];
   end
   assign perf_stall = r_perf_stall;
`endif

endmodule

// File: doc/raster_mem_arbiter.md
Name: raster_mem_arbiter

Overview:
- Parametrised N-channel Avalon-MM master arbiter for the rasterizer pipeline.
- Merges the per-stage masters (vertex fetch, depth fetch, z-test write-back, and future stages) onto one SDRAM-controller master port.
- Arbitration is round-robin. Read responses are routed back to the issuing channel through an in-order tag FIFO.
- Instantiated once per rasterizer unit, between the pipeline stages and the SDRAM controller.

Parameters:
- NUM_CH, 3, number of upstream channels (2..8)
- ADDR_W, 26, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_PENDING, 8, outstanding-read depth (power of 2, >=2)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- ch_address  in  NUM_CH*ADDR_W  per-channel address; channel i occupies slice i
- ch_read  in  NUM_CH  per-channel read request
- ch_write  in  NUM_CH  per-channel write request
- ch_byteenable  in  NUM_CH*DATA_W/8  per-channel byteenable
- ch_writedata  in  NUM_CH*DATA_W  per-channel write data
- ch_waitrequest  out  NUM_CH  per-channel waitrequest
- ch_readdata  out  DATA_W  read data, broadcast to all channels
- ch_readdatavalid  out  NUM_CH  one-hot read-data strobe
- m_address  out  ADDR_W  downstream address
- m_read  out  1  downstream read
- m_write  out  1  downstream write
- m_byteenable  out  DATA_W/8  downstream byteenable
- m_writedata  out  DATA_W  downstream write data
- m_waitrequest  in  1  downstream waitrequest
- m_readdata  in  DATA_W  downstream read data
- m_readdatavalid  in  1  downstream read-data valid
- err_orphan  out  1  sticky: readdatavalid arrived with the tag FIFO empty

Behaviour:
- Reset (async, active-high):
  - rr_ptr=0, lock=0, tag FIFO empty, err_orphan=0.
  - m_read=m_write=0, ch_readdatavalid=0, ch_waitrequest=all 1.
- Eligibility: channel i is eligible if ch_write[i], or (ch_read[i] and tag FIFO not full). A channel asserting both read and write is a protocol error; write takes priority.
- Grant, unlocked: combinational round-robin. The first eligible channel starting at rr_ptr, wrapping NUM_CH-1 -> 0, wins. No eligible channel -> m_read=m_write=0.
- Grant, locked: lock_ch is forced as the grant regardless of other requests.
- Downstream signals are a combinational mux of the granted channel, giving zero-cycle request latency.
- ch_waitrequest[i] = ~(grant==i & request_presented & ~m_waitrequest). Non-granted channels always see 1.
- Accept = (m_read|m_write) & ~m_waitrequest.
  - On accept: lock<=0, rr_ptr<=(grant+1) mod NUM_CH.
  - If the accepted transfer is a read, push the grant ID into the tag FIFO.
- Presented but m_waitrequest=1: lock<=1, lock_ch<=grant. The grant is held until accept (Avalon hold rule).
- Read return:
  - On m_readdatavalid: pop the FIFO head and assert ch_readdatavalid[head] in the same cycle, combinationally.
  - ch_readdata=m_readdata at all times.
- Simultaneous push and pop: occupancy is unchanged. A push into a full FIFO cannot occur because eligibility gates it.
- m_readdatavalid with the FIFO empty: no channel strobe is asserted, and err_orphan<=1 until reset.
- Writes are never blocked by a full tag FIFO.
- Reset mid-transaction: in-flight tags are discarded; downstream responses that arrive afterwards set err_orphan.

Optional Feature:
- RASTER_ARB_PERF_EN defined:
  - Adds output perf_grants (NUM_CH*32) counting accepts per channel.
  - Adds output perf_stall (32) counting cycles with a request presented and m_waitrequest=1.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port exists and no counters are synthesised.

Test Plan:
- Round-robin: ch0,1,2 hold reads, m_waitrequest=0 -> grants 0,1,2,0,... on consecutive cycles; tags pushed in order 0,1,2.
- Lock: ch1 write addr 0x100, m_waitrequest=1 for 3 cycles while ch0 requests -> m_address stays 0x100 for 4 cycles; ch1 accepted in cycle 4, then ch2 or ch0 per rr_ptr.
- Routing: reads from ch2 then ch0 accepted; readdatavalid returns 0xAAAA then 0xBBBB -> ch_readdatavalid=3'b100 with 0xAAAA, then 3'b001 with 0xBBBB.
- Full: MAX_PENDING=8 reads outstanding, ch0 read plus ch1 write -> ch1 write granted, ch0 waits; one readdatavalid -> ch0 read accepted next cycle.
- Orphan / reset: m_readdatavalid with empty FIFO -> no strobe, err_orphan=1; assert reset mid-lock -> all outputs return to reset values within the same cycle.
